bin_erosion_3x3: RTL and testbench

Streaming 3x3 binary erosion stage. It sits directly downstream of `binarization` in the camera pipeline and cleans single-pixel noise from the 1-bit image before the SDRAM write port.
- Consumes the `post_*` and `monoc` stream.
- Produces an identically timed stream, delayed by 3 clocks.
- Each output bit is the AND of a 3x3 neighbourhood, built from two 1-bit line buffers.

---
 rtl/bin_erosion_pkg.sv | 15 +
 rtl/bin_line_buffer.sv | 27 ++
 rtl/bin_erosion_3x3.sv | 172 +++++++++++++++++
 tb/tb_bin_erosion_3x3.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bin_erosion_pkg.sv
// rtl/bin_erosion_pkg.sv - shared constants for the 3x3 binary erosion stage
// BIN_EROSION_EDGE_ZERO_EN selects a 0 border instead of the default 1 border.
package bin_erosion_pkg;

    localparam int BE_LATENCY = 3;

`ifdef BIN_EROSION_EDGE_ZERO_EN
    localparam logic BE_BORDER = 1'b0;
`else
    localparam logic BE_BORDER = 1'b1;
`endif

    localparam logic [1:0] BE_ROW_SAT = 2'd2;

endpackage

// File: rtl/bin_line_buffer.sv
// rtl/bin_line_buffer.sv - 1-bit simple dual-port line RAM, read-before-write, registered read
// No reset: consumers mask rows that have not been written in the current frame.
module bin_line_buffer #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    logic mem [DEPTH];
    logic rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bin_erosion_3x3.sv
// rtl/bin_erosion_3x3.sv - streaming 3x3 binary erosion, 3-clock latency on all outputs
// Border value set by BIN_EROSION_EDGE_ZERO_EN (undefined: out-of-frame neighbours read as 1).
module bin_erosion_3x3
    import bin_erosion_pkg::*;
#(
    parameter int IMG_WIDTH = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre_vsync,
    input  logic pre_hsync,
    input  logic pre_de,
    input  logic pre_bit,
    output logic post_vsync,
    output logic post_hsync,
    output logic post_de,
    output logic post_bit
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam int CW = $clog2(IMG_WIDTH) + 1;
    localparam logic [CW-1:0] COL_LIMIT = CW'(IMG_WIDTH);

    logic                  vsync_prev_q, vsync_prev_d;
    logic                  line_open_q, line_open_d;
    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [1:0]            row_cnt_q, row_cnt_d;
    logic [BE_LATENCY-1:0] vs_dly_q, vs_dly_d;
    logic [BE_LATENCY-1:0] hs_dly_q, hs_dly_d;
    logic [BE_LATENCY-1:0] de_dly_q, de_dly_d;
    logic                  s1_bit_q, s1_bit_d;
    logic [AW-1:0]         s1_addr_q, s1_addr_d;
    logic                  s1_in_range_q, s1_in_range_d;
    logic                  s1_c0_q, s1_c0_d;
    logic                  s1_clt2_q, s1_clt2_d;
    logic [1:0]            s1_row_q, s1_row_d;
    logic [8:0]            win_q, win_d;
    logic                  s2_ok_q, s2_ok_d;
    logic                  s2_c0_q, s2_c0_d;
    logic                  s2_clt2_q, s2_clt2_d;
    logic                  post_bit_q, post_bit_d;

    logic                  vsync_rise, line_end, pix_in_range;
    logic [CW-1:0]         pix_col;
    logic [1:0]            pix_row;
    logic [2:0]            vec, col1, col2;
    logic                  lb1_rd, lb2_rd;

    bin_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk     (clk),
        .wr_en   (pre_de & pix_in_range),
        .wr_addr (pix_col[AW-1:0]),
        .wr_data (pre_bit),
        .rd_addr (pix_col[AW-1:0]),
        .rd_data (lb1_rd)
    );

    // lb2 takes lb1's pre-write data one clock later, once its registered read lands.
    bin_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .clk     (clk),
        .wr_en   (de_dly_q[0] & s1_in_range_q),
        .wr_addr (s1_addr_q),
        .wr_data (lb1_rd),
        .rd_addr (pix_col[AW-1:0]),
        .rd_data (lb2_rd)
    );

    always_comb begin
        vsync_rise   = pre_vsync & ~vsync_prev_q;
        // A pre_de drop while pre_hsync is still high is an in-line gap, not a line end.
        line_end     = line_open_q & ~pre_de & ~pre_hsync;
        pix_col      = pre_vsync ? '0 : col_cnt_q;
        pix_row      = vsync_rise ? 2'd0 : row_cnt_q;
        pix_in_range = pix_col < COL_LIMIT;

        vsync_prev_d = pre_vsync;
        line_open_d  = line_open_q;
        if (pre_de) begin
            line_open_d = 1'b1;
        end else if (line_end) begin
            line_open_d = 1'b0;
        end

        col_cnt_d = col_cnt_q;
        if (pre_vsync) begin
            col_cnt_d = '0;
        end else if (pre_de) begin
            col_cnt_d = (col_cnt_q == '1) ? col_cnt_q : col_cnt_q + 1'b1;
        end else if (line_end) begin
            col_cnt_d = '0;
        end

        row_cnt_d = row_cnt_q;
        if (vsync_rise) begin
            row_cnt_d = 2'd0;
        end else if (line_end && row_cnt_q < BE_ROW_SAT) begin
            row_cnt_d = row_cnt_q + 2'd1;
        end

        vs_dly_d = {vs_dly_q[BE_LATENCY-2:0], pre_vsync};
        hs_dly_d = {hs_dly_q[BE_LATENCY-2:0], pre_hsync};
        de_dly_d = {de_dly_q[BE_LATENCY-2:0], pre_de};

        s1_bit_d      = pre_bit;
        s1_addr_d     = pix_col[AW-1:0];
        s1_in_range_d = pix_in_range;
        s1_c0_d       = pix_col == '0;
        s1_clt2_d     = pix_col < CW'(2);
        s1_row_d      = pix_row;

        vec[0] = s1_bit_q;
        vec[1] = (s1_row_q == 2'd0) ? BE_BORDER : lb1_rd;
        vec[2] = (s1_row_q < BE_ROW_SAT) ? BE_BORDER : lb2_rd;

        win_d     = de_dly_q[0] ? {win_q[5:0], vec} : win_q;
        s2_ok_d   = s1_in_range_q & ~s1_c0_q & (s1_row_q != 2'd0);
        s2_c0_d   = s1_c0_q;
        s2_clt2_d = s1_clt2_q;

        col1       = s2_c0_q ? {3{BE_BORDER}} : win_q[5:3];
        col2       = s2_clt2_q ? {3{BE_BORDER}} : win_q[8:6];
        post_bit_d = de_dly_q[1] & s2_ok_q & (&{col2, col1, win_q[2:0]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q  <= 1'b0;
            line_open_q   <= 1'b0;
            col_cnt_q     <= '0;
            row_cnt_q     <= 2'd0;
            vs_dly_q      <= '0;
            hs_dly_q      <= '0;
            de_dly_q      <= '0;
            s1_bit_q      <= 1'b0;
            s1_addr_q     <= '0;
            s1_in_range_q <= 1'b0;
            s1_c0_q       <= 1'b0;
            s1_clt2_q     <= 1'b0;
            s1_row_q      <= 2'd0;
            win_q         <= '0;
            s2_ok_q       <= 1'b0;
            s2_c0_q       <= 1'b0;
            s2_clt2_q     <= 1'b0;
            post_bit_q    <= 1'b0;
        end else begin
            vsync_prev_q  <= vsync_prev_d;
            line_open_q   <= line_open_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            vs_dly_q      <= vs_dly_d;
            hs_dly_q      <= hs_dly_d;
            de_dly_q      <= de_dly_d;
            s1_bit_q      <= s1_bit_d;
            s1_addr_q     <= s1_addr_d;
            s1_in_range_q <= s1_in_range_d;
            s1_c0_q       <= s1_c0_d;
            s1_clt2_q     <= s1_clt2_d;
            s1_row_q      <= s1_row_d;
            win_q         <= win_d;
            s2_ok_q       <= s2_ok_d;
            s2_c0_q       <= s2_c0_d;
            s2_clt2_q     <= s2_clt2_d;
            post_bit_q    <= post_bit_d;
        end
    end

    assign post_vsync = vs_dly_q[BE_LATENCY-1];
    assign post_hsync = hs_dly_q[BE_LATENCY-1];
    assign post_de    = de_dly_q[BE_LATENCY-1];
    assign post_bit   = post_bit_q;

endmodule

// File: tb/tb_bin_erosion_3x3.sv
// tb/tb_bin_erosion_3x3.sv - directed bench for bin_erosion_3x3 on 8x8 frames
// Honours BIN_EROSION_EDGE_ZERO_EN for the expected border value.
module tb_bin_erosion_3x3;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int MAXW = 10;

`ifdef BIN_EROSION_EDGE_ZERO_EN
    localparam logic BORDER = 1'b0;
`else
    localparam logic BORDER = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pre_vsync = 1'b0;
    logic pre_hsync = 1'b0;
    logic pre_de = 1'b0;
    logic pre_bit = 1'b0;
    logic post_vsync, post_hsync, post_de, post_bit;

    int n_vec = 0;
    int n_err = 0;

    logic img [0:H-1][0:MAXW-1];
    int   row_len [0:H-1];
    logic h_vs [0:2];
    logic h_hs [0:2];
    logic h_de [0:2];
    logic h_bit [0:2];

    always #5 clk = ~clk;

    bin_erosion_3x3 #(.IMG_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_vsync  (pre_vsync),
        .pre_hsync  (pre_hsync),
        .pre_de     (pre_de),
        .pre_bit    (pre_bit),
        .post_vsync (post_vsync),
        .post_hsync (post_hsync),
        .post_de    (post_de),
        .post_bit   (post_bit)
    );

    // Plain 2D erosion centred on (r-1,c-1); out-of-frame neighbours read as BORDER.
    function automatic logic golden(input int r, input int c);
        logic acc;
        acc = 1'b1;
        if (c >= W || r == 0 || c == 0) return 1'b0;
        for (int rr = r - 2; rr <= r; rr++) begin
            for (int cc = c - 2; cc <= c; cc++) begin
                if (rr < 0 || cc < 0) acc = acc & BORDER;
                else acc = acc & img[rr][cc];
            end
        end
        return acc;
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            h_vs[i] = 1'b0; h_hs[i] = 1'b0; h_de[i] = 1'b0; h_bit[i] = 1'b0;
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against inputs driven three steps earlier, then drive new inputs.
    task automatic step(input logic vs, input logic hs, input logic de, input logic b, input logic exp_b);
        @(negedge clk);
        check_bit("post_vsync", post_vsync, h_vs[2]);
        check_bit("post_hsync", post_hsync, h_hs[2]);
        check_bit("post_de", post_de, h_de[2]);
        if (h_de[2]) check_bit("post_bit", post_bit, h_bit[2]);
        for (int i = 2; i > 0; i--) begin
            h_vs[i] = h_vs[i-1]; h_hs[i] = h_hs[i-1]; h_de[i] = h_de[i-1]; h_bit[i] = h_bit[i-1];
        end
        h_vs[0] = vs; h_hs[0] = hs; h_de[0] = de; h_bit[0] = exp_b;
        pre_vsync = vs; pre_hsync = hs; pre_de = de; pre_bit = b;
    endtask

    task automatic run_frame(input bit gaps, input int stop_row);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < row_len[r]; c++) begin
                if (r == stop_row && c == 3) return;
                if (gaps && c > 0 && $urandom_range(0, 2) == 0) step(0, 1, 0, 0, 0);
                step(0, 1, 1, img[r][c], golden(r, c));
            end
            for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic fill(input logic v);
        for (int r = 0; r < H; r++) begin
            row_len[r] = W;
            for (int c = 0; c < MAXW; c++) img[r][c] = v;
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++) begin
            row_len[r] = W;
            for (int c = 0; c < MAXW; c++) img[r][c] = ($urandom_range(0, 5) != 0);
        end
    endtask

    initial begin
        clear_hist();
        repeat (2) @(negedge clk);
        #1;
        check_bit("reset_vsync", post_vsync, 1'b0);
        check_bit("reset_hsync", post_hsync, 1'b0);
        check_bit("reset_de", post_de, 1'b0);
        check_bit("reset_bit", post_bit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(1'b1);
        run_frame(1'b0, -1);

        img[3][3] = 1'b0;
        run_frame(1'b0, -1);

        fill_random();
        run_frame(1'b0, -1);
        run_frame(1'b1, -1);

        row_len[2] = MAXW;
        run_frame(1'b0, -1);
        row_len[2] = W;

        run_frame(1'b0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_vsync", post_vsync, 1'b0);
        check_bit("rst_mid_hsync", post_hsync, 1'b0);
        check_bit("rst_mid_de", post_de, 1'b0);
        check_bit("rst_mid_bit", post_bit, 1'b0);
        clear_hist();
        pre_vsync = 1'b0; pre_hsync = 1'b0; pre_de = 1'b0; pre_bit = 1'b0;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        fill_random();
        run_frame(1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
